// File: rtl/rst_seq_wdt.sv
// Reset sequencer + watchdog: synchronized POR, fixed hold, staggered per-domain release, SW/WDT re-entry.
// Latency: domains fall one edge after a sampled request; no backpressure, all outputs registered.
module rst_seq_wdt #(
  parameter int N_DOM    = 4,
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 8,
  parameter int WDT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  input  logic             wdt_en,
  input  logic             wdt_kick,
  input  logic [WDT_W-1:0] wdt_load,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             all_ready,
  output logic             wdt_expired,
  output logic [1:0]       rst_cause
);

  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] REL  = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  localparam int MAX_CYC = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LD = CNT_W'(STEP_CYC - 1);

  logic [1:0]       state;
  logic             sync_q;
  logic [CNT_W-1:0] seq_cnt;
  logic [WDT_W-1:0] wdt_cnt;
  logic [N_DOM-1:0] dom_shift;
  logic             wdt_fire;

  // Next release pattern: one more low-order domain out of reset.
  always_comb begin
    dom_shift    = dom_rst_n << 1;
    dom_shift[0] = 1'b1;
  end

  // A kick or disabled watchdog reloads instead of decrementing, so neither can fire.
  always_comb begin
    wdt_fire = (state == RUN) && wdt_en && !wdt_kick &&
               (wdt_load != '0) && (wdt_cnt == WDT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      sync_q      <= 1'b0;
      seq_cnt     <= '0;
      wdt_cnt     <= '0;
      dom_rst_n   <= '0;
      all_ready   <= 1'b0;
      wdt_expired <= 1'b0;
      rst_cause   <= 2'd0;
    end else begin
      case (state)
        // sync_q is the first synchronizer stage; the state register is the second.
        SYNC: begin
          sync_q <= 1'b1;
          if (sync_q) begin
            state   <= HOLD;
            seq_cnt <= HOLD_LD;
          end
        end
        default: begin
          if (sw_rst_req || wdt_fire) begin
            state     <= HOLD;
            seq_cnt   <= HOLD_LD;
            dom_rst_n <= '0;
            all_ready <= 1'b0;
            if (sw_rst_req) begin
              rst_cause <= 2'd1;
            end else begin
              rst_cause   <= 2'd2;
              wdt_expired <= 1'b1;
            end
          end else begin
            case (state)
              HOLD, REL: begin
                if (seq_cnt == '0) begin
                  dom_rst_n <= dom_shift;
                  if (&dom_shift) begin
                    state     <= RUN;
                    all_ready <= 1'b1;
                    wdt_cnt   <= wdt_load;
                  end else begin
                    state   <= REL;
                    seq_cnt <= STEP_LD;
                  end
                end else begin
                  seq_cnt <= seq_cnt - CNT_W'(1);
                end
              end
              RUN: begin
                if (wdt_kick || !wdt_en) begin
                  wdt_cnt <= wdt_load;
                end else if (wdt_cnt != '0) begin
                  wdt_cnt <= wdt_cnt - WDT_W'(1);
                end
              end
              default: begin
                state <= state;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_wdt.sv
// Self-checking bench for rst_seq_wdt: edge-arithmetic reference model plus directed and random scenarios.
module tb_rst_seq_wdt;

  localparam int N        = 4;
  localparam int HOLD     = 16;
  localparam int STEP     = 8;
  localparam int REL_SPAN = HOLD + (N - 1) * STEP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw_rst_req = 1'b0;
  logic        wdt_en = 1'b0;
  logic        wdt_kick = 1'b0;
  logic [15:0] wdt_load = 16'd0;
  logic [N-1:0] dom_rst_n;
  logic        all_ready;
  logic        wdt_expired;
  logic [1:0]  rst_cause;
  logic [7:0]  obs;

  int checks = 0;
  int failures = 0;

  // Reference model: edges since release, last reset-event edge, last watchdog reload.
  int       cyc = 0;
  int       ev = -1;
  int       r_edge = 0;
  int       r_val = 0;
  logic     expired_m = 1'b0;
  logic [1:0] cause_m = 2'd0;

  rst_seq_wdt #(.N_DOM(N), .HOLD_CYC(HOLD), .STEP_CYC(STEP), .WDT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .wdt_en(wdt_en),
    .wdt_kick(wdt_kick), .wdt_load(wdt_load), .dom_rst_n(dom_rst_n),
    .all_ready(all_ready), .wdt_expired(wdt_expired), .rst_cause(rst_cause)
  );

  assign obs = {dom_rst_n, all_ready, wdt_expired, rst_cause};

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; ev <= -1; r_edge <= 0; r_val <= 0; expired_m <= 1'b0; cause_m <= 2'd0;
    end else begin
      cyc <= cyc + 1;
      if (cyc + 1 == 2) begin
        ev <= 2;
      end else if (cyc + 1 > 2) begin
        if (sw_rst_req) begin
          ev <= cyc + 1; cause_m <= 2'd1;
        end else if (cyc + 1 == ev + REL_SPAN) begin
          r_edge <= cyc + 1; r_val <= int'(wdt_load);
        end else if (cyc + 1 > ev + REL_SPAN) begin
          if (wdt_kick || !wdt_en) begin
            r_edge <= cyc + 1; r_val <= int'(wdt_load);
          end else if (wdt_load != 16'd0 && r_val != 0 && cyc + 1 == r_edge + r_val) begin
            ev <= cyc + 1; cause_m <= 2'd2; expired_m <= 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [7:0] exp_vec();
    logic [N-1:0] d;
    logic rdy;
    for (int i = 0; i < N; i++) d[i] = (ev >= 0) && (cyc >= ev + HOLD + i * STEP);
    rdy = (ev >= 0) && (cyc >= ev + REL_SPAN);
    return {d, rdy, expired_m, cause_m};
  endfunction

  task automatic por(input logic en, input logic [15:0] ld);
    @(negedge clk);
    rst_n = 1'b0; sw_rst_req = 1'b0; wdt_kick = 1'b0; wdt_en = en; wdt_load = ld;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      failures++; $display("FAIL reset_state got=%b exp=%b", obs, 8'h00);
    end
  endtask

  task automatic test_por();
    logic [3:0] dc;
    por(1'b0, 16'd0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL por_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (k == 17 || k == 18 || k == 26 || k == 34 || k == 41 || k == 42) begin
        dc = {k >= 42, k >= 34, k >= 26, k >= 18};
        checks++;
        if ({dom_rst_n, all_ready, rst_cause} !== {dc, k >= 42, 2'd0}) begin
          failures++;
          $display("FAIL por_edges edge=%0d got=%b/%b/%0d exp=%b/%b/0", k, dom_rst_n, all_ready, rst_cause, dc, k >= 42);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    logic [3:0] dc;
    repeat (99 - cyc) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL sw_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
    end
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    checks++;
    if ({dom_rst_n, all_ready, rst_cause} !== {4'b0000, 1'b0, 2'd1}) begin
      failures++; $display("FAIL sw_assert edge=%0d got=%b/%b/%0d exp=0000/0/1", cyc, dom_rst_n, all_ready, rst_cause);
    end
    repeat (45) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL sw_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (cyc == 115 || cyc == 116 || cyc == 124 || cyc == 132 || cyc == 140) begin
        dc = {cyc >= 140, cyc >= 132, cyc >= 124, cyc >= 116};
        checks++;
        if (dom_rst_n !== dc) begin
          failures++; $display("FAIL sw_edges edge=%0d got=%b exp=%b", cyc, dom_rst_n, dc);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    por(1'b1, 16'd50);
    repeat (140) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL wdt_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (cyc == 91) begin
        checks++;
        if (obs !== {4'b1111, 1'b1, 1'b0, 2'd0}) begin
          failures++; $display("FAIL wdt_before edge=91 got=%b exp=%b", obs, {4'b1111, 1'b1, 1'b0, 2'd0});
        end
      end
      if (cyc == 92) begin
        checks++;
        if (obs !== {4'b0000, 1'b0, 1'b1, 2'd2}) begin
          failures++; $display("FAIL wdt_expire edge=92 got=%b exp=%b", obs, {4'b0000, 1'b0, 1'b1, 2'd2});
        end
      end
      if (cyc == 108 || cyc == 132) begin
        checks++;
        if (dom_rst_n !== ((cyc == 108) ? 4'b0001 : 4'b1111)) begin
          failures++; $display("FAIL wdt_rerelease edge=%0d got=%b", cyc, dom_rst_n);
        end
      end
    end
    wdt_en = 1'b0;
  endtask

  task automatic test_kick_and_zero();
    por(1'b1, 16'd50);
    repeat (1042) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL kick_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      wdt_kick = ((cyc + 1) % 40 == 0);
    end
    checks++;
    if ({wdt_expired, all_ready} !== 2'b01) begin
      failures++; $display("FAIL kick_no_expiry got=%b%b exp=01", wdt_expired, all_ready);
    end
    wdt_load = 16'd0; wdt_kick = 1'b1;
    @(negedge clk);
    wdt_kick = 1'b0;
    repeat (200) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL zero_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
    end
    checks++;
    if (wdt_expired !== 1'b0) begin
      failures++; $display("FAIL zero_no_expiry got=%b exp=0", wdt_expired);
    end
    wdt_load = 16'd20; wdt_kick = 1'b1;
    @(negedge clk);
    wdt_kick = 1'b0;
    repeat (19) @(negedge clk);
    wdt_kick = 1'b1;
    @(negedge clk);
    wdt_kick = 1'b0;
    checks++;
    if ({wdt_expired, all_ready} !== 2'b01) begin
      failures++; $display("FAIL kick_on_expiry_edge got=%b%b exp=01", wdt_expired, all_ready);
    end
    repeat (19) @(negedge clk);
    checks++;
    if (wdt_expired !== 1'b0) begin
      failures++; $display("FAIL kick_reload_early got=%b exp=0", wdt_expired);
    end
    @(negedge clk);
    checks++;
    if ({wdt_expired, rst_cause, dom_rst_n} !== {1'b1, 2'd2, 4'b0000}) begin
      failures++; $display("FAIL kick_reload_expiry got=%b/%0d/%b exp=1/2/0000", wdt_expired, rst_cause, dom_rst_n);
    end
  endtask

  task automatic test_sw_mid_rel();
    por(1'b0, 16'd0);
    repeat (29) @(negedge clk);
    checks++;
    if (dom_rst_n !== 4'b0011) begin
      failures++; $display("FAIL midrel_before edge=29 got=%b exp=0011", dom_rst_n);
    end
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    checks++;
    if ({dom_rst_n, rst_cause} !== {4'b0000, 2'd1}) begin
      failures++; $display("FAIL midrel_assert edge=30 got=%b/%0d exp=0000/1", dom_rst_n, rst_cause);
    end
    repeat (16) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL midrel_model cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (cyc == 45 || cyc == 46) begin
        checks++;
        if (dom_rst_n !== ((cyc == 46) ? 4'b0001 : 4'b0000)) begin
          failures++; $display("FAIL midrel_edges edge=%0d got=%b", cyc, dom_rst_n);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    por(1'b1, 16'd10);
    repeat (80) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL async_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
    end
    checks++;
    if ({dom_rst_n, wdt_expired} !== {4'b0011, 1'b1}) begin
      failures++; $display("FAIL async_midrel got=%b/%b exp=0011/1", dom_rst_n, wdt_expired);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      failures++; $display("FAIL async_assert got=%b exp=%b", obs, 8'h00);
    end
    @(negedge clk);
    wdt_en = 1'b0;
    rst_n = 1'b1;
    repeat (45) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL async_repor cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      if (cyc == 42) begin
        checks++;
        if (obs !== {4'b1111, 1'b1, 1'b0, 2'd0}) begin
          failures++; $display("FAIL async_repor_done got=%b exp=%b", obs, {4'b1111, 1'b1, 1'b0, 2'd0});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 4; ep++) begin
      por(1'($urandom % 2), 16'($urandom_range(8, 80)));
      repeat (700) begin
        @(negedge clk);
        checks++;
        if (obs !== exp_vec()) begin
          failures++; $display("FAIL random ep=%0d cyc=%0d got=%b exp=%b", ep, cyc, obs, exp_vec());
        end
        sw_rst_req = ($urandom % 200 == 0);
        wdt_kick   = ($urandom % 48 == 0);
        if ($urandom % 300 == 0) wdt_en = ~wdt_en;
        if ($urandom % 150 == 0) wdt_load = 16'($urandom_range(0, 80));
      end
    end
    sw_rst_req = 1'b0;
    wdt_kick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_por();
    test_sw_reset();
    test_watchdog();
    test_kick_and_zero();
    test_sw_mid_rel();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq_wdt.md
# rst_seq_wdt

Reset sequencer and watchdog for the clock/reset infrastructure. Takes the board-level asynchronous active-low reset, synchronizes its release, holds all downstream domains in reset for a fixed interval, then releases `N_DOM` domain resets one at a time. While running, it services a software reset request and a watchdog timer. Either event re-enters the same hold/release sequence. Sits between the clock generator and the DUT blocks, replacing ad-hoc delay-based reset release.

## Interface
- `N_DOM`, 4: number of sequenced reset domains (1..16).
- `HOLD_CYC`, 16: cycles all domains stay in reset after a reset event (≥1).
- `STEP_CYC`, 8: cycles between successive domain releases (≥1).
- `WDT_W`, 16: watchdog counter width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw_rst_req` in 1: software reset request, sampled each cycle.
- `wdt_en` in 1: watchdog enable.
- `wdt_kick` in 1: watchdog reload strobe.
- `wdt_load` in `WDT_W`: watchdog timeout in cycles; 0 means never expire.
- `dom_rst_n` out `N_DOM`: per-domain active-low reset. Bit 0 is released first.
- `all_ready` out 1: high when every domain is released and the block is in RUN.
- `wdt_expired` out 1: sticky flag that the watchdog fired.
- `rst_cause` out 2: last reset source. 0 = POR, 1 = SW, 2 = WDT.

## Operation
- FSM states: SYNC, HOLD, REL, RUN.
- Reset values (`rst_n` low, asynchronous): state SYNC, `dom_rst_n` = 0, `all_ready` = 0, `wdt_expired` = 0, `rst_cause` = 0, all counters 0.
- **SYNC:** a 2-flop synchronizer on `rst_n` release. The first rising edge with `rst_n` high is edge 1. At edge 2 the FSM enters HOLD.
- **HOLD:** all `dom_rst_n` = 0. A hold counter counts `HOLD_CYC` edges, then the FSM enters REL.
- **REL:** `dom_rst_n[0]` rises on the HOLD→REL edge. Each further `STEP_CYC` edges, the next bit rises. Released bits stay high.
- **REL → RUN:** when bit `N_DOM-1` rises, the FSM enters RUN on that same edge and `all_ready` rises on that edge.
- **Software reset:** `sw_rst_req` sampled high in HOLD, REL or RUN causes, on that edge:
  - all `dom_rst_n` = 0 and `all_ready` = 0;
  - `rst_cause` = 1;
  - hold counter reloaded, FSM to HOLD.
  - A request during HOLD therefore restarts the hold interval.
  - `sw_rst_req` is ignored in SYNC.
- **Watchdog:** active only in RUN.
  - On the edge entering RUN, the counter loads `wdt_load`.
  - In RUN, the counter reloads `wdt_load` whenever `wdt_kick` = 1 or `wdt_en` = 0. Otherwise it decrements by 1.
  - When `wdt_en` = 1, `wdt_load` ≠ 0, the counter is 1, and it would decrement, the watchdog fires on that edge:
    - `wdt_expired` = 1;
    - `rst_cause` = 2;
    - domains are reasserted and the FSM goes to HOLD, exactly as for a software reset.
- **Priority on the same edge:**
  - `sw_rst_req` beats watchdog expiry: `rst_cause` = 1 and `wdt_expired` is unchanged.
  - `wdt_kick` beats expiry: the counter reloads and there is no expiry.
- `wdt_expired` is cleared only by `rst_n`.
- `rst_n` assertion at any time, including mid-REL, returns all outputs to reset values immediately (asynchronously) and the FSM to SYNC.
- A `wdt_load` change in RUN takes effect at the next reload.

## Timing
- POR, with a reset event at edge e = 2:
  - `dom_rst_n[i]` rises at edge e + `HOLD_CYC` + i·`STEP_CYC`.
  - `all_ready` rises together with bit `N_DOM-1`.
  - With default parameters: bits rise at edges 18, 26, 34, 42; `all_ready` rises at edge 42.
- SW/WDT event at edge k: same formula with e = k. Domains fall on edge k, i.e. 1-cycle latency from the sampled request.
- Watchdog with the last reload at edge r and no kicks: expiry occurs at edge r + `wdt_load`.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- **POR, default parameters:** release `rst_n` → `dom_rst_n` goes 0001, 0011, 0111, 1111 at edges 18/26/34/42; `all_ready` high at 42; `rst_cause` = 0.
- **SW reset in RUN:** `sw_rst_req` 1-cycle pulse at edge 100 → `dom_rst_n` = 0 at edge 100; bits rise at 116/124/132/140; `rst_cause` = 1.
- **Watchdog expiry:** `wdt_en` = 1, `wdt_load` = 50, no kicks, RUN entered at edge 42 → expiry at edge 92; `wdt_expired` = 1; `rst_cause` = 2; domains re-released at 108/116/124/132.
- **Kick and `wdt_load` = 0:**
  - Kick every 40 cycles with `wdt_load` = 50 → never expires over 1000 cycles.
  - `wdt_load` = 0 → no expiry.
  - Kick on the expiry edge → no expiry.
- **SW request mid-REL:** `sw_rst_req` at edge 30 (bit 0 and bit 1 released) → all bits 0 at edge 30; bit 0 rises again at edge 46.
- **Asynchronous `rst_n` mid-REL:** assert `rst_n` between edges → `dom_rst_n` = 0 without waiting for a clock edge; `wdt_expired` = 0; the full POR sequence repeats on release.
